// File: rtl/fwd_hazard_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_pkg
//  Purpose  : Shared encodings for the forwarding / hazard unit: EX operand
//             select codes and the multi-cycle scoreboard state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package fwd_pkg;

    // EX operand mux select codes; 2'b11 is never produced.
    localparam logic [1:0] FWD_REG   = 2'b00;  // register-file value
    localparam logic [1:0] FWD_EXMEM = 2'b01;  // bypass from EX/MEM
    localparam logic [1:0] FWD_MEMWB = 2'b10;  // bypass from MEM/WB

    // Multi-cycle unit tracker states.
    localparam int         MC_STATE_W = 2;
    localparam logic [1:0] MC_IDLE    = 2'b00;
    localparam logic [1:0] MC_BUSY    = 2'b01;
    localparam logic [1:0] MC_WB      = 2'b10;

endpackage : fwd_pkg
`default_nettype wire

// File: rtl/fwd_hazard_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_hazard_unit_if
//  Purpose  : Bundle of pipeline-register taps and control outputs exchanged
//             between the pipeline datapath (master) and the hazard unit
//             (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface fwd_hazard_unit_if #(
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 16
);

    // ID stage
    logic [NUM_SRC*REG_AW-1:0] id_rs_i;
    logic [NUM_SRC-1:0]        id_rs_used_i;
    logic [REG_AW-1:0]         id_rd_i;
    logic                      id_regwrite_i;
    logic                      id_is_mc_i;
    // EX stage (ID/EX register)
    logic [NUM_SRC*REG_AW-1:0] id_ex_rs_i;
    logic [REG_AW-1:0]         id_ex_rd_i;
    logic                      id_ex_regwrite_i;
    logic                      id_ex_memread_i;
    // MEM stage (EX/MEM register)
    logic [REG_AW-1:0]         ex_mem_rd_i;
    logic                      ex_mem_regwrite_i;
    // WB stage (MEM/WB register)
    logic [REG_AW-1:0]         mem_wb_rd_i;
    logic                      mem_wb_regwrite_i;
    // Multi-cycle issue and performance control
    logic                      mc_issue_i;
    logic [REG_AW-1:0]         mc_rd_i;
    logic                      perf_clr_i;
    // Outputs from the hazard unit
    logic [NUM_SRC*2-1:0]      fwd_sel_o;
    logic                      stall_o;
    logic                      bubble_o;
    logic                      mc_busy_o;
    logic                      mc_wb_o;
    logic [REG_AW-1:0]         mc_wb_rd_o;
    logic [CNT_W-1:0]          stall_cnt_o;
    logic                      err_o;

    // Pipeline side: drives the stage taps, consumes the controls.
    modport master (
        output id_rs_i, id_rs_used_i, id_rd_i, id_regwrite_i, id_is_mc_i,
               id_ex_rs_i, id_ex_rd_i, id_ex_regwrite_i, id_ex_memread_i,
               ex_mem_rd_i, ex_mem_regwrite_i, mem_wb_rd_i, mem_wb_regwrite_i,
               mc_issue_i, mc_rd_i, perf_clr_i,
        input  fwd_sel_o, stall_o, bubble_o, mc_busy_o, mc_wb_o, mc_wb_rd_o,
               stall_cnt_o, err_o
    );

    // Hazard unit side.
    modport slave (
        input  id_rs_i, id_rs_used_i, id_rd_i, id_regwrite_i, id_is_mc_i,
               id_ex_rs_i, id_ex_rd_i, id_ex_regwrite_i, id_ex_memread_i,
               ex_mem_rd_i, ex_mem_regwrite_i, mem_wb_rd_i, mem_wb_regwrite_i,
               mc_issue_i, mc_rd_i, perf_clr_i,
        output fwd_sel_o, stall_o, bubble_o, mc_busy_o, mc_wb_o, mc_wb_rd_o,
               stall_cnt_o, err_o
    );

endinterface : fwd_hazard_unit_if
`default_nettype wire

// File: rtl/fwd_hazard_unit_mc_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : mc_scoreboard
//  Purpose  : Tracks the single non-pipelined multi-cycle unit. Latches the
//             destination of the issuing op, counts a fixed execute latency,
//             then raises a one-cycle writeback strobe. Issues arriving while
//             the unit is occupied are dropped and flagged as a sticky error.
//  Revision : 1.0  initial release
// ============================================================================
module mc_scoreboard
    import fwd_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int MC_LAT = 4
) (
    input  wire logic              clk_i,
    input  wire logic              rst_i,      // asynchronous, active low
    input  wire logic              issue,
    input  wire logic [REG_AW-1:0] issue_rd,
    output logic                   busy,
    output logic [REG_AW-1:0]      pend_rd,
    output logic                   wb,
    output logic [REG_AW-1:0]      wb_rd,
    output logic                   err
);

    // Counter only needs to hold MC_LAT-1.
    localparam int LAT_W = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;
    localparam logic [LAT_W-1:0] c_LAT_INIT = LAT_W'(MC_LAT - 1);

    logic [MC_STATE_W-1:0] r_state;
    logic [MC_STATE_W-1:0] w_state_nxt;
    logic [LAT_W-1:0]      r_cnt;
    logic [REG_AW-1:0]     r_pend_rd;
    logic                  r_err;

    logic w_idle;
    assign w_idle = (r_state == MC_IDLE);

    // State register; reset abandons any in-flight op.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= MC_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: IDLE -> BUSY on issue, BUSY -> WB when latency expires, WB -> IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            MC_IDLE: if (issue)        w_state_nxt = MC_BUSY;
            MC_BUSY: if (r_cnt == '0)  w_state_nxt = MC_WB;
            MC_WB:                     w_state_nxt = MC_IDLE;
            default:                   w_state_nxt = MC_IDLE;
        endcase
    end

    // Latency counter, pending destination and sticky error flag.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt     <= '0;
            r_pend_rd <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_idle && issue) begin
                r_cnt     <= c_LAT_INIT;
                r_pend_rd <= issue_rd;
            end else if ((r_state == MC_BUSY) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            // A second issue cannot be accepted by a non-pipelined unit.
            if (issue && !w_idle) begin
                r_err <= 1'b1;
            end
        end
    end

    // Outputs decoded from state; the strobe and its tag are zero outside WB.
    always_comb begin
        busy    = !w_idle;
        wb      = (r_state == MC_WB);
        wb_rd   = (r_state == MC_WB) ? r_pend_rd : '0;
        pend_rd = r_pend_rd;
        err     = r_err;
    end

endmodule : mc_scoreboard
`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_hazard_unit
//  Purpose  : EX operand forwarding for NUM_SRC read ports, load-use and
//             multi-cycle (RAW/WAW/structural) hazard detection driving the
//             PC/IF-ID hold and ID/EX bubble, plus a saturating stall counter.
//  Revision : 1.0  initial release
// ============================================================================
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2,
    parameter int MC_LAT  = 4,
    parameter int CNT_W   = 16
) (
    input  wire logic         clk_i,
    input  wire logic         rst_i,      // asynchronous, active low
    fwd_hazard_unit_if.slave  bus
);

    logic [NUM_SRC-1:0] w_lu_hit;    // per-slot load-use match
    logic [NUM_SRC-1:0] w_raw_hit;   // per-slot match against the pending mc dest
    logic [1:0]         w_sel [NUM_SRC];

    logic               w_mc_busy;
    logic [REG_AW-1:0]  w_pend_rd;
    logic               w_mc_wb;
    logic [REG_AW-1:0]  w_mc_wb_rd;
    logic               w_mc_err;

    logic               w_lu;
    logic               w_mh;
    logic               w_waw;
    logic               w_stall;
    logic [CNT_W-1:0]   r_stall_cnt;

    // Per-slot forwarding select and hazard matches.
    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        logic [REG_AW-1:0] w_ex_rs;
        logic [REG_AW-1:0] w_id_rs;
        logic              w_hit_exmem;
        logic              w_hit_memwb;

        assign w_ex_rs = bus.id_ex_rs_i[k*REG_AW +: REG_AW];
        assign w_id_rs = bus.id_rs_i[k*REG_AW +: REG_AW];

        // r0 is hard-wired to zero, so a write to it is never a bypass source.
        assign w_hit_exmem = bus.ex_mem_regwrite_i && (bus.ex_mem_rd_i != '0) &&
                             (bus.ex_mem_rd_i == w_ex_rs);
        assign w_hit_memwb = bus.mem_wb_regwrite_i && (bus.mem_wb_rd_i != '0) &&
                             (bus.mem_wb_rd_i == w_ex_rs);

        // The younger EX/MEM result wins over MEM/WB.
        assign w_sel[k] = w_hit_exmem ? FWD_EXMEM :
                          w_hit_memwb ? FWD_MEMWB : FWD_REG;

        assign w_lu_hit[k]  = bus.id_rs_used_i[k] && (w_id_rs == bus.id_ex_rd_i);
        assign w_raw_hit[k] = bus.id_rs_used_i[k] && (w_id_rs == w_pend_rd) &&
                              (w_pend_rd != '0);
    end

    // Pack per-slot selects onto the flat output bus.
    always_comb begin
        bus.fwd_sel_o = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            bus.fwd_sel_o[k*2 +: 2] = w_sel[k];
        end
    end

    mc_scoreboard #(
        .REG_AW (REG_AW),
        .MC_LAT (MC_LAT)
    ) u_mc_scoreboard (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .issue    (bus.mc_issue_i),
        .issue_rd (bus.mc_rd_i),
        .busy     (w_mc_busy),
        .pend_rd  (w_pend_rd),
        .wb       (w_mc_wb),
        .wb_rd    (w_mc_wb_rd),
        .err      (w_mc_err)
    );

    // Hazard reduction: a load result is not bypassable until MEM completes,
    // and the mc unit blocks dependent, overwriting or competing ops until
    // its writeback cycle is over.
    always_comb begin
        w_lu    = bus.id_ex_memread_i && bus.id_ex_regwrite_i &&
                  (bus.id_ex_rd_i != '0) && (|w_lu_hit);
        w_waw   = bus.id_regwrite_i && (bus.id_rd_i == w_pend_rd) &&
                  (w_pend_rd != '0);
        w_mh    = w_mc_busy && (bus.id_is_mc_i || (|w_raw_hit) || w_waw);
        w_stall = w_lu || w_mh;
    end

    // Saturating stall-cycle counter; software clear takes priority.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall_cnt <= '0;
        end else if (bus.perf_clr_i) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    // Drive the remaining control outputs.
    always_comb begin
        bus.stall_o     = w_stall;
        bus.bubble_o    = w_stall;
        bus.mc_busy_o   = w_mc_busy;
        bus.mc_wb_o     = w_mc_wb;
        bus.mc_wb_rd_o  = w_mc_wb_rd;
        bus.stall_cnt_o = r_stall_cnt;
        bus.err_o       = w_mc_err;
    end

endmodule : fwd_hazard_unit
`default_nettype wire

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
Parametrised successor to the two-source EX forwarding block. It produces per-source EX forwarding selects for NUM_SRC read ports and detects load-use hazards in ID, generating the stall and bubble controls. It also tracks one non-pipelined multi-cycle unit (mul/div) with a fixed-latency FSM: RAW, WAW and structural stalls against it, plus its writeback strobe. It sits between the ID/EX, EX/MEM and MEM/WB pipeline registers and drives the PC/IF-ID hold, the ID/EX flush and the EX operand muxes.

Parameters:
REG_AW, 5, register address width
NUM_SRC, 2, source operands per instruction (read ports), range 1..4
MC_LAT, 4, multi-cycle unit execute latency in cycles, range 1..(2^CNT_W)
CNT_W, 16, width of the saturating stall performance counter

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-low reset
id_rs_i  in  NUM_SRC*REG_AW  ID-stage source regs; slot k at [k*REG_AW +: REG_AW]
id_rs_used_i  in  NUM_SRC  slot k is actually read by the ID instruction
id_rd_i  in  REG_AW  ID-stage destination reg
id_regwrite_i  in  1  ID instruction writes id_rd_i
id_is_mc_i  in  1  ID instruction is a multi-cycle op
id_ex_rs_i  in  NUM_SRC*REG_AW  EX-stage source regs (same slot layout)
id_ex_rd_i  in  REG_AW  EX-stage destination
id_ex_regwrite_i  in  1  EX-stage regwrite
id_ex_memread_i  in  1  EX-stage instruction is a load
ex_mem_rd_i  in  REG_AW  MEM-stage destination
ex_mem_regwrite_i  in  1  MEM-stage regwrite
mem_wb_rd_i  in  REG_AW  WB-stage destination
mem_wb_regwrite_i  in  1  WB-stage regwrite
mc_issue_i  in  1  multi-cycle op enters EX this cycle
mc_rd_i  in  REG_AW  destination of the issuing multi-cycle op
perf_clr_i  in  1  synchronous clear of stall_cnt_o
fwd_sel_o  out  NUM_SRC*2  per-slot EX operand select
stall_o  out  1  hold PC and IF/ID
bubble_o  out  1  zero ID/EX control bits next edge
mc_busy_o  out  1  FSM not IDLE
mc_wb_o  out  1  multi-cycle writeback strobe (one cycle)
mc_wb_rd_o  out  REG_AW  writeback destination, valid with mc_wb_o
stall_cnt_o  out  CNT_W  saturating count of stall_o cycles
err_o  out  1  sticky protocol error

Behaviour:
- Forwarding (combinational), per slot k, evaluated independently:
  - 01 if ex_mem_regwrite_i and ex_mem_rd_i != 0 and ex_mem_rd_i == rs[k].
  - Otherwise 10 if mem_wb_regwrite_i and mem_wb_rd_i != 0 and mem_wb_rd_i == rs[k].
  - Otherwise 00. Encoding 11 is never driven.
  - EX/MEM has priority over MEM/WB.
- Load-use hazard (lu): id_ex_memread_i and id_ex_regwrite_i and id_ex_rd_i != 0 and any used slot k has id_rs[k] == id_ex_rd_i.
- Multi-cycle hazard (mh), asserted when state != IDLE and any of the following holds:
  - id_is_mc_i (structural);
  - a used id_rs[k] == pend_rd and pend_rd != 0 (RAW);
  - id_regwrite_i and id_rd_i == pend_rd and pend_rd != 0 (WAW).
- Stall outputs: stall_o = bubble_o = lu | mh, combinational. Both hold in the WB cycle as well, so release happens on the edge after mc_wb_o.
- Multi-cycle FSM (states IDLE, BUSY, WB):
  - IDLE: on mc_issue_i, latch pend_rd = mc_rd_i, load cnt = MC_LAT-1, go to BUSY.
  - BUSY: if cnt == 0 go to WB, else decrement cnt.
  - WB: mc_wb_o = 1 and mc_wb_rd_o = pend_rd; go to IDLE next edge.
  - Latency: issue sampled at edge 0 gives mc_wb_o high between edge MC_LAT and edge MC_LAT+1. With MC_LAT = 1, WB follows BUSY after one cycle.
  - mc_busy_o is 1 in BUSY and WB.
  - mc_issue_i while not IDLE: ignored, err_o set (sticky until reset).
  - mc_wb_rd_o is 0 outside WB.
- stall_cnt_o:
  - perf_clr_i has priority: clears to 0, even when stall_o is 1.
  - Otherwise increments on every edge where stall_o = 1.
  - Saturates at all-ones.
- Reset (asynchronous, any time including mid-BUSY):
  - state IDLE, cnt 0, pend_rd 0, stall_cnt_o 0, err_o 0, mc_wb_o 0, mc_wb_rd_o 0.
  - The pending op is lost; upstream flushes the pipeline on the same reset.
  - Combinational outputs follow their inputs with the FSM held idle.

Decomposition:
- Package fwd_pkg holds:
  - FWD_REG = 2'b00, FWD_EXMEM = 2'b01, FWD_MEMWB = 2'b10;
  - the MC state encoding (IDLE = 2'b00, BUSY = 2'b01, WB = 2'b10).
- One sub-module, mc_scoreboard: the FSM, cnt, pend_rd and err logic. It exports busy, pend_rd and wb.
- Forwarding, hazard OR-reduction and the perf counter stay in the top level, using generate loops over NUM_SRC.

Test Plan:
- NUM_SRC = 2: ex_mem_rd = 3 and mem_wb_rd = 3, both regwrite, id_ex_rs = {3,3} -> fwd_sel = {01,01}. Repeat with ex_mem_rd = 0 -> {10,10}. Repeat with regwrite = 0 on both -> {00,00}.
- Load-use: id_ex_memread = 1, id_ex_rd = 5, id_rs slot1 = 5 with used = 1 -> stall_o = bubble_o = 1 for that cycle. Same case with used[1] = 0 -> 0. id_ex_rd = 0 -> 0.
- MC_LAT = 4: mc_issue with rd = 7 at edge 0 -> mc_busy_o = 1 from edge 0, mc_wb_o = 1 with mc_wb_rd_o = 7 only between edges 4 and 5, and IDLE after edge 5. An ID read of r7 during this window gives stall_o = 1 through the WB cycle; a read of r8 does not stall.
- WAW and structural: while BUSY with pend_rd = 7, id_regwrite with id_rd = 7 -> stall. id_is_mc = 1 -> stall. Force mc_issue_i during BUSY -> err_o = 1 sticky, and the FSM timing is unchanged.
- Reset mid-BUSY (cnt = 2): drop rst_i asynchronously -> mc_busy_o, mc_wb_o, stall_cnt_o and err_o go to 0 immediately. No WB strobe afterwards.
- CNT_W = 4: hold stall for 20 cycles -> stall_cnt_o saturates at 15. perf_clr_i with stall_o still high -> 0 next edge.
